odd_parity_frame_rx: RTL

//   Serial receive stage that sits downstream of the odd-parity generator.

---
 rtl/odd_parity_frame_rx_if.sv | 24 ++
 rtl/odd_parity_frame_rx.sv | 88 ++++++++
 2 files changed

// File: rtl/odd_parity_frame_rx_if.sv
// Stream bundle for the odd-parity frame receiver.
// Carries the serial bit input handshake and the buffered word output handshake.
interface odd_parity_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic              abort;
  logic [DATA_W-1:0] data_out;
  logic              par_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output bit_in, bit_valid, abort, out_ready,
    input  bit_ready, data_out, par_err, out_valid
  );

  modport slave (
    input  bit_in, bit_valid, abort, out_ready,
    output bit_ready, data_out, par_err, out_valid
  );
endinterface

// File: rtl/odd_parity_frame_rx.sv
// Serial odd-parity frame receiver: gathers DATA_W data bits plus a parity bit,
// checks odd parity and holds the word in a one-entry output buffer.
module odd_parity_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  odd_parity_frame_rx_if.slave bus,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int                  CNT_BITS = $clog2(DATA_W + 1);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(DATA_W - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_DATA, ST_PAR, ST_HOLD} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_BITS-1:0] bit_cnt;
  logic                par_acc;
  logic [DATA_W-1:0]   shreg;
  logic                accept;
  logic                frame_err;

  assign accept    = bus.bit_valid & bus.bit_ready;
  assign frame_err = ~(par_acc ^ bus.bit_in);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_DATA;
    else     state <= state_nxt;
  end

  // Abort only restarts a partial frame; a buffered word waits for its handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: begin
        if (bus.abort)                            state_nxt = ST_DATA;
        else if (accept && (bit_cnt == LAST_IDX)) state_nxt = ST_PAR;
      end
      ST_PAR: begin
        if (bus.abort)   state_nxt = ST_DATA;
        else if (accept) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) state_nxt = ST_DATA;
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  always_comb begin
    bus.bit_ready = (state != ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      par_acc       <= 1'b0;
      shreg         <= '0;
      bus.data_out  <= '0;
      bus.par_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      err_cnt       <= '0;
    end else if ((state != ST_HOLD) && bus.abort) begin
      bit_cnt <= '0;
      par_acc <= 1'b0;
    end else if ((state == ST_DATA) && accept) begin
      // Each bit lands directly in its final position, so no shift direction logic.
      for (int i = 0; i < DATA_W; i++) begin
        if (bit_cnt == CNT_BITS'(MSB_FIRST ? (DATA_W - 1 - i) : i)) shreg[i] <= bus.bit_in;
      end
      par_acc <= par_acc ^ bus.bit_in;
      bit_cnt <= bit_cnt + CNT_BITS'(1);
    end else if ((state == ST_PAR) && accept) begin
      bus.data_out  <= shreg;
      bus.par_err   <= frame_err;
      bus.out_valid <= 1'b1;
      if (frame_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
      bit_cnt <= '0;
      par_acc <= 1'b0;
    end else if ((state == ST_HOLD) && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
